// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART state encoding and line-level constants
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // 0 selects even parity: data plus parity bit must XOR to this value.
  localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - one-bit-per-clock UART frame receiver with parity/stop checks
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX_data,
  output logic             parity_bit_err,
  output logic             stop_bit_err,
  output logic [WIDTH-1:0] RX_data_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  uart_state_e      state;
  uart_state_e      next_state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (RX_data == LINE_START) next_state = DATA;
      DATA:    if (bit_cnt == LAST_BIT) next_state = PARITY;
      PARITY:  next_state = STOP;
      STOP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt        <= '0;
      shift_reg      <= '0;
      RX_data_out    <= '0;
      parity_bit_err <= 1'b0;
      stop_bit_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (RX_data == LINE_START) begin
            bit_cnt        <= '0;
            parity_bit_err <= 1'b0;
            stop_bit_err   <= 1'b0;
          end
        end
        DATA: begin
          // Shift in from the top so the first data bit lands at index 0.
          shift_reg <= {RX_data, shift_reg[WIDTH-1:1]};
          if (bit_cnt != LAST_BIT) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          parity_bit_err <= (^shift_reg) ^ RX_data ^ PARITY_EVEN;
        end
        STOP: begin
          stop_bit_err <= (RX_data != LINE_STOP);
          RX_data_out  <= shift_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic       clk;
  logic       rst;
  logic       RX_data;
  logic       parity_bit_err;
  logic       stop_bit_err;
  logic [7:0] RX_data_out;

  int n_cmp;
  int n_bad;

  uart_rx #(.WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .RX_data        (RX_data),
    .parity_bit_err (parity_bit_err),
    .stop_bit_err   (stop_bit_err),
    .RX_data_out    (RX_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one line bit at the falling edge, then sample just after the rising edge.
  task automatic send_bit(input logic b);
    @(negedge clk);
    RX_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input logic exp_perr, input logic [7:0] prev_out);
    send_bit(1'b0);
    check("start_clears_perr", {7'b0, parity_bit_err}, 8'h00);
    check("start_clears_serr", {7'b0, stop_bit_err}, 8'h00);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    check("parity_err", {7'b0, parity_bit_err}, {7'b0, exp_perr});
    check("out_held_mid_frame", RX_data_out, prev_out);
    send_bit(s);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    RX_data = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", RX_data_out, 8'h00);
    check("reset_perr", {7'b0, parity_bit_err}, 8'h00);
    check("reset_serr", {7'b0, stop_bit_err}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Idle line for 20 cycles: nothing may happen.
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1);
      check("idle_out", RX_data_out, 8'h00);
      check("idle_state", {6'b0, dut.state}, {6'b0, IDLE});
    end
    check("idle_perr", {7'b0, parity_bit_err}, 8'h00);
    check("idle_serr", {7'b0, stop_bit_err}, 8'h00);

    // Clean frame 0xD7 (line order 1,1,1,0,1,0,1,1), parity 0.
    send_frame(8'hD7, 1'b0, 1'b1, 1'b0, 8'h00);
    check("d7_out", RX_data_out, 8'hD7);
    check("d7_perr", {7'b0, parity_bit_err}, 8'h00);
    check("d7_serr", {7'b0, stop_bit_err}, 8'h00);
    send_bit(1'b1);

    // Same data with a wrong parity bit.
    send_frame(8'hD7, 1'b1, 1'b1, 1'b1, 8'hD7);
    check("d7bad_out", RX_data_out, 8'hD7);
    check("d7bad_perr", {7'b0, parity_bit_err}, 8'h01);
    check("d7bad_serr", {7'b0, stop_bit_err}, 8'h00);
    send_bit(1'b1);
    check("perr_holds_idle", {7'b0, parity_bit_err}, 8'h01);

    // 0x55 with a missing stop bit.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 8'hD7);
    check("55_out", RX_data_out, 8'h55);
    check("55_perr", {7'b0, parity_bit_err}, 8'h00);
    check("55_serr", {7'b0, stop_bit_err}, 8'h01);

    // Back-to-back 0x0F and 0xF0 with no idle gap; stop error clears at start.
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 8'h55);
    check("0f_out", RX_data_out, 8'h0F);
    check("0f_serr", {7'b0, stop_bit_err}, 8'h00);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 8'h0F);
    check("f0_out", RX_data_out, 8'hF0);
    check("f0_perr", {7'b0, parity_bit_err}, 8'h00);
    check("f0_serr", {7'b0, stop_bit_err}, 8'h00);

    // Reset after the 4th data bit of a frame.
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    rst     = 1'b1;
    RX_data = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out", RX_data_out, 8'h00);
    check("midrst_perr", {7'b0, parity_bit_err}, 8'h00);
    check("midrst_serr", {7'b0, stop_bit_err}, 8'h00);
    check("midrst_state", {6'b0, dut.state}, {6'b0, IDLE});
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send_bit(1'b1);
      check("postrst_idle_out", RX_data_out, 8'h00);
    end
    check("postrst_state", {6'b0, dut.state}, {6'b0, IDLE});

    // Clean 0xA3 frame after the aborted one.
    send_frame(8'hA3, 1'b0, 1'b1, 1'b0, 8'h00);
    check("a3_out", RX_data_out, 8'hA3);
    check("a3_perr", {7'b0, parity_bit_err}, 8'h00);
    check("a3_serr", {7'b0, stop_bit_err}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
